// File: rtl/csr_perf_dump_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// csr_perf_dump_pkg : CSR window offsets, frame constants, read-sequencer states
// Rev 1.0
// ----------------------------------------------------------------------------
package csr_perf_dump_pkg;

    // Offsets within the CSR window, shared with the CSR counter block
    localparam logic [31:0] CSR_CYCLELO = 32'h0000_0000;
    localparam logic [31:0] CSR_CYCLEHI = 32'h0000_0004;
    localparam logic [31:0] CSR_INSTRET = 32'h0000_0008;
    localparam logic [31:0] CSR_STALL   = 32'h0000_000C;
    localparam logic [31:0] CSR_FLUSH   = 32'h0000_0010;
    localparam logic [31:0] CSR_EPC     = 32'h0000_0014;
    localparam logic [31:0] CSR_CAUSE   = 32'h0000_0018;
    localparam logic [31:0] CSR_IDLE    = 32'h0000_00FC;

    localparam logic [15:0] FRAME_MAGIC = 16'h5046;
    localparam int          MAX_WORDS   = 8;

    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_RD_HI1     = 4'd1,
        ST_RD_LO      = 4'd2,
        ST_RD_HI2     = 4'd3,
        ST_RD_INSTRET = 4'd4,
        ST_RD_STALL   = 4'd5,
        ST_RD_FLUSH   = 4'd6,
        ST_RD_EPC     = 4'd7,
        ST_RD_CAUSE   = 4'd8,
        ST_EMIT       = 4'd9
    } state_t;

    function automatic logic [31:0] frame_hdr(input logic [7:0] nwords, input logic torn);
        return {FRAME_MAGIC, nwords, 7'd0, torn};
    endfunction

endpackage
`default_nettype wire

// File: rtl/csr_perf_dump_frame_tx.sv
`default_nettype none
// ----------------------------------------------------------------------------
// perf_frame_tx : frozen word buffer and valid/ready emitter with XOR checksum
// Rev 1.0
// ----------------------------------------------------------------------------
module perf_frame_tx
    import csr_perf_dump_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        load,
    input  logic [3:0]                  ndata,
    input  logic [MAX_WORDS-1:0][31:0]  words,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [31:0]                 out_data,
    output logic                        out_last,
    output logic                        frame_done
);

    logic [MAX_WORDS-1:0][31:0] word_buf;
    logic [3:0]                 ndata_q;
    logic [3:0]                 idx;
    logic [31:0]                csum;
    logic                       xfer;
    logic [3:0]                 idx_nxt;
    logic [31:0]                csum_nxt;

    assign xfer       = out_valid && out_ready;
    assign idx_nxt    = idx + 4'd1;
    assign csum_nxt   = csum ^ out_data;
    assign frame_done = xfer && out_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_buf  <= '0;
            ndata_q   <= '0;
            idx       <= '0;
            csum      <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else if (load) begin
            word_buf  <= words;
            ndata_q   <= ndata;
            idx       <= '0;
            csum      <= '0;
            out_valid <= 1'b1;
            out_data  <= words[0];
            out_last  <= 1'b0;
        end else if (xfer) begin
            csum <= csum_nxt;
            if (out_last) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
                out_data  <= '0;
            end else if (idx_nxt == ndata_q) begin
                // every data word has gone out; the running XOR becomes the trailer
                idx      <= idx_nxt;
                out_data <= csum_nxt;
                out_last <= 1'b1;
            end else begin
                idx      <= idx_nxt;
                out_data <= word_buf[idx_nxt[2:0]];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/csr_perf_dump.sv
`default_nettype none
// ----------------------------------------------------------------------------
// csr_perf_dump : CSR read sequencer with tear-free cycle snapshot, framed dump
// Rev 1.0
// ----------------------------------------------------------------------------
module csr_perf_dump
    import csr_perf_dump_pkg::*;
#(
    parameter logic [31:0] CSR_BASE     = 32'hFFFF_F000,
    parameter int          MAX_RETRY    = 3,
    parameter int          PERIOD       = 0,
    parameter int          INCLUDE_TRAP = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [31:0] csr_addr,
    input  logic [31:0] csr_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_last,
    output logic        busy,
    output logic        done
);

    localparam bit          TRAP      = (INCLUDE_TRAP != 0);
    localparam logic [3:0]  NDATA     = TRAP ? 4'd8 : 4'd6;
    localparam logic [31:0] ADDR_IDLE = CSR_BASE + CSR_IDLE;

    state_t      state;
    logic [7:0]  retry_cnt;
    logic        torn;
    logic [31:0] hi1;
    logic [31:0] cyc_lo;
    logic [31:0] cyc_hi;
    logic [31:0] instret;
    logic [31:0] stall;
    logic [31:0] flush_q;
    logic [31:0] epc;
    logic        tick;
    logic        load;
    logic        frame_done;
    logic [31:0] flush_w;
    logic [MAX_WORDS-1:0][31:0] frame_words;

    generate
        if (PERIOD > 0) begin : g_period
            logic [31:0] period_cnt;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    period_cnt <= '0;
                else if (period_cnt == 32'(PERIOD - 1))
                    period_cnt <= '0;
                else
                    period_cnt <= period_cnt + 32'd1;
            end
            assign tick = (period_cnt == 32'(PERIOD - 1));
        end else begin : g_no_period
            assign tick = 1'b0;
        end
    endgenerate

    // The final read feeds the buffer straight from csr_rdata so the frame starts
    // on the edge that samples it rather than one cycle later.
    assign load    = (state == ST_RD_CAUSE) || (!TRAP && (state == ST_RD_FLUSH));
    assign flush_w = (state == ST_RD_FLUSH) ? csr_rdata : flush_q;

    always_comb begin
        frame_words    = '0;
        frame_words[0] = frame_hdr({4'd0, NDATA} + 8'd1, torn);
        frame_words[1] = cyc_lo;
        frame_words[2] = cyc_hi;
        frame_words[3] = instret;
        frame_words[4] = stall;
        frame_words[5] = flush_w;
        frame_words[6] = epc;
        frame_words[7] = csr_rdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            csr_addr  <= ADDR_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            retry_cnt <= '0;
            torn      <= 1'b0;
            hi1       <= '0;
            cyc_lo    <= '0;
            cyc_hi    <= '0;
            instret   <= '0;
            stall     <= '0;
            flush_q   <= '0;
            epc       <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start || tick) begin
                        state     <= ST_RD_HI1;
                        csr_addr  <= CSR_BASE + CSR_CYCLEHI;
                        busy      <= 1'b1;
                        retry_cnt <= '0;
                        torn      <= 1'b0;
                    end
                end
                ST_RD_HI1: begin
                    hi1      <= csr_rdata;
                    csr_addr <= CSR_BASE + CSR_CYCLELO;
                    state    <= ST_RD_LO;
                end
                ST_RD_LO: begin
                    cyc_lo   <= csr_rdata;
                    csr_addr <= CSR_BASE + CSR_CYCLEHI;
                    state    <= ST_RD_HI2;
                end
                ST_RD_HI2: begin
                    // out of retries: keep this attempt's HI/LO pair and flag it torn
                    if ((csr_rdata == hi1) || (retry_cnt >= 8'(MAX_RETRY))) begin
                        cyc_hi   <= csr_rdata;
                        torn     <= (csr_rdata != hi1);
                        csr_addr <= CSR_BASE + CSR_INSTRET;
                        state    <= ST_RD_INSTRET;
                    end else begin
                        retry_cnt <= retry_cnt + 8'd1;
                        csr_addr  <= CSR_BASE + CSR_CYCLEHI;
                        state     <= ST_RD_HI1;
                    end
                end
                ST_RD_INSTRET: begin
                    instret  <= csr_rdata;
                    csr_addr <= CSR_BASE + CSR_STALL;
                    state    <= ST_RD_STALL;
                end
                ST_RD_STALL: begin
                    stall    <= csr_rdata;
                    csr_addr <= CSR_BASE + CSR_FLUSH;
                    state    <= ST_RD_FLUSH;
                end
                ST_RD_FLUSH: begin
                    flush_q <= csr_rdata;
                    if (TRAP) begin
                        csr_addr <= CSR_BASE + CSR_EPC;
                        state    <= ST_RD_EPC;
                    end else begin
                        csr_addr <= ADDR_IDLE;
                        state    <= ST_EMIT;
                    end
                end
                ST_RD_EPC: begin
                    epc      <= csr_rdata;
                    csr_addr <= CSR_BASE + CSR_CAUSE;
                    state    <= ST_RD_CAUSE;
                end
                ST_RD_CAUSE: begin
                    csr_addr <= ADDR_IDLE;
                    state    <= ST_EMIT;
                end
                ST_EMIT: begin
                    if (frame_done) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    csr_addr <= ADDR_IDLE;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

    perf_frame_tx u_tx (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .ndata      (NDATA),
        .words      (frame_words),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .frame_done (frame_done)
    );

endmodule
`default_nettype wire

// File: tb/tb_csr_perf_dump.sv
`timescale 1ns/1ps
`default_nettype none
// Bench for csr_perf_dump: directed frame vectors plus reset, period and no-trap sequences.
module tb_csr_perf_dump;
    import csr_perf_dump_pkg::*;

    localparam logic [31:0] BASE      = 32'hFFFF_F000;
    localparam logic [31:0] IDLE_ADDR = 32'hFFFF_F0FC;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, rst_aux;
    logic        start, out_ready;
    logic [31:0] csr_addr, csr_rdata, out_data;
    logic        out_valid, out_last, busy, done;

    logic        start_nt, ready_nt;
    logic [31:0] addr_nt, rdata_nt, data_nt;
    logic        valid_nt, last_nt, busy_nt, done_nt;

    logic        start_p, ready_p;
    logic [31:0] addr_p, rdata_p, data_p;
    logic        valid_p, last_p, busy_p, done_p;

    int tests = 0;
    int fails = 0;

    // CSR model: HI behaviour selected by mode (0 fixed, 1 bumps once, 2 changes every read)
    int          mode = 0;
    int          hi_reads = 0;
    int          hi_base = 0;
    logic [31:0] hi_main;

    function automatic logic [31:0] csr_model(input logic [31:0] a, input logic [31:0] hi);
        case (a - BASE)
            CSR_CYCLELO: return 32'h0000_0010;
            CSR_CYCLEHI: return hi;
            CSR_INSTRET: return 32'd5;
            CSR_STALL:   return 32'd2;
            CSR_FLUSH:   return 32'd1;
            CSR_EPC:     return 32'h0000_0100;
            CSR_CAUSE:   return 32'h0000_0002;
            default:     return 32'hDEAD_BEEF;
        endcase
    endfunction

    always_comb begin
        hi_main = 32'd1;
        case (mode)
            1: hi_main = ((hi_reads - hi_base) >= 1) ? 32'd2 : 32'd1;
            2: hi_main = 32'(1 + hi_reads - hi_base);
            default: hi_main = 32'd1;
        endcase
    end

    assign csr_rdata = csr_model(csr_addr, hi_main);
    assign rdata_nt  = csr_model(addr_nt, 32'd1);
    assign rdata_p   = csr_model(addr_p, 32'd1);

    always @(posedge clk) if (csr_addr == BASE + CSR_CYCLEHI) hi_reads <= hi_reads + 1;

    bit seen_trap = 1'b0;
    always @(posedge clk)
        if (addr_nt == BASE + CSR_EPC || addr_nt == BASE + CSR_CAUSE) seen_trap <= 1'b1;

    csr_perf_dump dut (
        .clk(clk), .rst_n(rst_n), .start(start), .csr_addr(csr_addr), .csr_rdata(csr_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .busy(busy), .done(done)
    );

    csr_perf_dump #(.INCLUDE_TRAP(0)) dut_nt (
        .clk(clk), .rst_n(rst_aux), .start(start_nt), .csr_addr(addr_nt), .csr_rdata(rdata_nt),
        .out_valid(valid_nt), .out_ready(ready_nt), .out_data(data_nt), .out_last(last_nt),
        .busy(busy_nt), .done(done_nt)
    );

    csr_perf_dump #(.PERIOD(100)) dut_p (
        .clk(clk), .rst_n(rst_aux), .start(start_p), .csr_addr(addr_p), .csr_rdata(rdata_p),
        .out_valid(valid_p), .out_ready(ready_p), .out_data(data_p), .out_last(last_p),
        .busy(busy_p), .done(done_p)
    );

    // Periodic instance monitor: cycle stamp of each done pulse and word/last counts
    int cyc_now = 0;
    int done_t[$];
    int words_p = 0;
    int lasts_p = 0;
    int words_at3 = -1;
    int lasts_at3 = -1;
    logic [31:0] data_at3 = 32'hFFFF_FFFF;
    logic busy_at3 = 1'b1;
    always @(negedge clk) begin
        cyc_now++;
        if (valid_p && ready_p) words_p++;
        if (valid_p && ready_p && last_p) lasts_p++;
        if (done_p && rst_aux) begin
            done_t.push_back(cyc_now);
            if (done_t.size() == 3) begin
                words_at3 = words_p;
                lasts_at3 = lasts_p;
                data_at3  = data_p;
                busy_at3  = busy_p;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    logic [31:0] got_w[16];
    bit          got_l[16];
    int          got_n;
    int          got_lat;

    task automatic run_frame(input bit rnd, input int restart_at);
        bit          stall_prev;
        bit          fin;
        logic [31:0] prev_d;
        logic        prev_l;
        got_n = 0; got_lat = -1; stall_prev = 1'b0; fin = 1'b0; prev_d = '0; prev_l = 1'b0;
        @(negedge clk);
        start = 1'b1;
        out_ready = 1'b0;
        for (int cyc = 1; cyc <= 300 && !fin; cyc++) begin
            @(negedge clk);
            start = (cyc == restart_at);
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (out_valid) begin
                if (got_lat < 0) got_lat = cyc;
                if (stall_prev) begin
                    check("stall_data", out_data, prev_d);
                    check("stall_last", 32'(out_last), 32'(prev_l));
                end
                if (out_ready && got_n < 16) begin
                    got_w[got_n] = out_data;
                    got_l[got_n] = out_last;
                    got_n++;
                    fin = out_last;
                end
                stall_prev = !out_ready;
                prev_d = out_data;
                prev_l = out_last;
            end else begin
                stall_prev = 1'b0;
            end
        end
        if (!fin) check("frame_timeout", 32'd0, 32'd1);
        @(negedge clk);
        out_ready = 1'b0;
        check("done_pulse", 32'(done), 32'd1);
        check("busy_end", 32'(busy), 32'd0);
        check("valid_end", 32'(out_valid), 32'd0);
        check("addr_end", csr_addr, IDLE_ADDR);
        @(negedge clk);
        check("done_single", 32'(done), 32'd0);
    endtask

    typedef struct {
        int          mode;
        bit          rnd;
        int          restart_at;
        logic [31:0] hdr;
        logic [31:0] hi;
        int          lat;
    } vec_t;

    vec_t        vecs[5];
    logic [31:0] exp_w[9];
    logic [31:0] x;
    int          n;

    initial begin
        rst_n = 1'b0; rst_aux = 1'b0;
        start = 1'b0; out_ready = 1'b0;
        start_nt = 1'b0; ready_nt = 1'b1;
        start_p = 1'b0; ready_p = 1'b1;

        vecs[0] = '{0, 1'b0, -1, 32'h5046_0900, 32'd1, 9};
        vecs[1] = '{0, 1'b1, -1, 32'h5046_0900, 32'd1, 9};
        vecs[2] = '{1, 1'b0, -1, 32'h5046_0900, 32'd2, 12};
        vecs[3] = '{2, 1'b0, -1, 32'h5046_0901, 32'd8, 18};
        vecs[4] = '{0, 1'b0, 4,  32'h5046_0900, 32'd1, 9};

        repeat (3) @(negedge clk);
        check("rst_addr", csr_addr, IDLE_ADDR);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", out_data, 32'd0);
        check("rst_last", 32'(out_last), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        rst_n = 1'b1; rst_aux = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            mode = vecs[i].mode;
            hi_base = hi_reads;
            run_frame(vecs[i].rnd, vecs[i].restart_at);
            exp_w[0] = vecs[i].hdr;   exp_w[1] = 32'h10;  exp_w[2] = vecs[i].hi;
            exp_w[3] = 32'd5;         exp_w[4] = 32'd2;   exp_w[5] = 32'd1;
            exp_w[6] = 32'h100;       exp_w[7] = 32'h2;
            x = '0;
            for (int k = 0; k < 8; k++) x = x ^ exp_w[k];
            exp_w[8] = x;
            check($sformatf("v%0d_count", i), 32'(got_n), 32'd9);
            for (int k = 0; k < 9 && k < got_n; k++) begin
                check($sformatf("v%0d_word%0d", i, k), got_w[k], exp_w[k]);
                check($sformatf("v%0d_last%0d", i, k), 32'(got_l[k]), (k == 8) ? 32'd1 : 32'd0);
            end
            check($sformatf("v%0d_latency", i), 32'(got_lat), 32'(vecs[i].lat));
        end

        // The start pulsed while busy must not queue a second frame
        n = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (out_valid || busy) n++;
        end
        check("no_queued_frame", 32'(n), 32'd0);

        // Reset while word 4 is presented
        mode = 0;
        hi_base = hi_reads;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int c = 0; c < 40 && !out_valid; c++) @(negedge clk);
        out_ready = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_last", 32'(out_last), 32'd0);
        check("midrst_data", out_data, 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_addr", csr_addr, IDLE_ADDR);
        @(negedge clk); rst_n = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        check("postrst_done", 32'(done), 32'd0);
        hi_base = hi_reads;
        run_frame(1'b0, -1);
        check("postrst_count", 32'(got_n), 32'd9);
        check("postrst_hdr", got_w[0], 32'h5046_0900);
        check("postrst_lo", got_w[1], 32'h10);
        check("postrst_csum", got_w[8], 32'h5046_0900 ^ 32'h10 ^ 32'd1 ^ 32'd5 ^ 32'd2 ^ 32'd1 ^ 32'h100 ^ 32'h2);

        // Frame without trap words
        @(negedge clk); start_nt = 1'b1;
        @(negedge clk); start_nt = 1'b0;
        n = 0;
        for (int c = 0; c < 40; c++) begin
            if (valid_nt && n < 16) begin
                got_w[n] = data_nt;
                got_l[n] = last_nt;
                n++;
            end
            @(negedge clk);
        end
        exp_w[0] = 32'h5046_0700; exp_w[1] = 32'h10; exp_w[2] = 32'd1;
        exp_w[3] = 32'd5;         exp_w[4] = 32'd2;  exp_w[5] = 32'd1;
        x = '0;
        for (int k = 0; k < 6; k++) x = x ^ exp_w[k];
        exp_w[6] = x;
        check("nt_count", 32'(n), 32'd7);
        for (int k = 0; k < 7 && k < n; k++) begin
            check($sformatf("nt_word%0d", k), got_w[k], exp_w[k]);
            check($sformatf("nt_last%0d", k), 32'(got_l[k]), (k == 6) ? 32'd1 : 32'd0);
        end
        check("nt_no_trap_reads", 32'(seen_trap), 32'd0);

        // Periodic instance: frames every 100 cycles with no start
        for (int c = 0; c < 400 && done_t.size() < 3; c++) @(negedge clk);
        check("period_frames", 32'(done_t.size()), 32'd3);
        if (done_t.size() >= 3) begin
            check("period_gap1", 32'(done_t[1] - done_t[0]), 32'd100);
            check("period_gap2", 32'(done_t[2] - done_t[1]), 32'd100);
            check("period_words", 32'(words_at3), 32'd27);
            check("period_lasts", 32'(lasts_at3), 32'd3);
            check("period_data_idle", data_at3, 32'd0);
            check("period_busy_idle", 32'(busy_at3), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
